// File: rtl/hqm_rcfwl_gclk_clkreq_fsm.sv
// ---------------------------------------------------------------------------
// hqm_rcfwl_gclk_clkreq_fsm
//
// Clock-request/acknowledge gating controller. It runs on the free-running
// post-DOP clock. It arbitrates level clock requests from NUM_REQ agents and
// drives a registered enable to the downstream clock gate. It provides:
//   - a programmable wake settle delay,
//   - an idle hysteresis before gating,
//   - a DFT enable override,
//   - a saturating wake-event counter.
//
// Ports
//   ckpostdop_free : free-running post-DOP clock (single domain)
//   rst_b          : asynchronous active-low reset
//   agent_req      : per-agent level clock requests
//   agent_ack      : per-agent registered acknowledge
//   cfg_hyst       : idle cycles before gating, sampled on HYST entry
//   cfg_wake_dly   : settle cycles after enable, sampled on WAKE entry
//   fdft_clken     : DFT override, forces clken_out high combinationally
//   clken_out      : enable to the downstream clock gate
//   clk_active     : high while the FSM is in ON
//   wake_events    : saturating count of OFF->WAKE transitions
//   state_dbg      : current FSM state (OFF=0, WAKE=1, ON=2, HYST=3)
//
// Handshake: agent_req/agent_ack form a four-phase level handshake. An agent
// raises req and holds it until it sees ack. ack is registered and is granted
// only while the FSM is in ON. After the agent drops req, ack drops on the
// next edge.
// ---------------------------------------------------------------------------
module hqm_rcfwl_gclk_clkreq_fsm #(
  parameter int NUM_REQ = 4,
  parameter int HYST_W  = 8,
  parameter int WAKE_W  = 4,
  parameter int CNT_W   = 16
) (
  input  logic               ckpostdop_free,
  input  logic               rst_b,
  input  logic [NUM_REQ-1:0] agent_req,
  output logic [NUM_REQ-1:0] agent_ack,
  input  logic [HYST_W-1:0]  cfg_hyst,
  input  logic [WAKE_W-1:0]  cfg_wake_dly,
  input  logic               fdft_clken,
  output logic               clken_out,
  output logic               clk_active,
  output logic [CNT_W-1:0]   wake_events,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_WAKE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_HYST = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WAKE_W-1:0] WAKE_ONE = {{(WAKE_W-1){1'b0}}, 1'b1};
  localparam logic [HYST_W-1:0] HYST_ONE = {{(HYST_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic               clken_q, clken_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic [HYST_W-1:0]  hyst_cnt_q, hyst_cnt_d;
  logic [CNT_W-1:0]   wake_events_q, wake_events_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               any_req;

  assign any_req = |agent_req;

  always_comb begin
    state_d       = state_q;
    clken_d       = clken_q;
    wake_cnt_d    = wake_cnt_q;
    hyst_cnt_d    = hyst_cnt_q;
    wake_events_d = wake_events_q;
    case (state_q)
      ST_OFF: begin
        if (any_req) begin
          state_d    = ST_WAKE;
          wake_cnt_d = cfg_wake_dly;
          clken_d    = 1'b1;
          // The counter saturates at all-ones and does not wrap.
          if (wake_events_q != {CNT_W{1'b1}}) begin
            wake_events_d = wake_events_q + CNT_ONE;
          end
        end
      end
      ST_WAKE: begin
        // WAKE always runs to completion, even if requests drop meanwhile.
        if (wake_cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          wake_cnt_d = wake_cnt_q - WAKE_ONE;
        end
      end
      ST_ON: begin
        if (!any_req) begin
          state_d    = ST_HYST;
          hyst_cnt_d = cfg_hyst;
        end
      end
      ST_HYST: begin
        // A request wins over expiry, including in the final cycle.
        if (any_req) begin
          state_d = ST_ON;
        end else if (hyst_cnt_q == '0) begin
          state_d = ST_OFF;
          clken_d = 1'b0;
        end else begin
          hyst_cnt_d = hyst_cnt_q - HYST_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
        clken_d = 1'b0;
      end
    endcase
  end

  // Acks are judged against the current state. A warm request is
  // therefore acked one edge later, and a cold request one edge after ON.
  assign ack_d = agent_req & {NUM_REQ{state_q == ST_ON}};

  always_ff @(posedge ckpostdop_free or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= ST_OFF;
      clken_q       <= 1'b0;
      wake_cnt_q    <= '0;
      hyst_cnt_q    <= '0;
      wake_events_q <= '0;
      ack_q         <= '0;
    end else begin
      state_q       <= state_d;
      clken_q       <= clken_d;
      wake_cnt_q    <= wake_cnt_d;
      hyst_cnt_q    <= hyst_cnt_d;
      wake_events_q <= wake_events_d;
      ack_q         <= ack_d;
    end
  end

  // The DFT override is combinational so it bypasses the register stage.
  assign clken_out   = clken_q | fdft_clken;
  assign clk_active  = (state_q == ST_ON);
  assign agent_ack   = ack_q;
  assign wake_events = wake_events_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_clkreq_fsm.sv
// ---------------------------------------------------------------------------
// tb_hqm_rcfwl_gclk_clkreq_fsm
//
// Directed bench with hand-computed expected values. The bench drives two
// instances from the same inputs:
//   - dut     : the default parameter set,
//   - dut_sat : CNT_W=2, used for the wake-event saturation check.
//
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// which is mid-cycle for the rising-edge design.
// ---------------------------------------------------------------------------
module tb_hqm_rcfwl_gclk_clkreq_fsm;

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_HYST = 2'd3;

  logic        clk;
  logic        rst_b;
  logic [3:0]  agent_req;
  logic [7:0]  cfg_hyst;
  logic [3:0]  cfg_wake_dly;
  logic        fdft_clken;

  logic [3:0]  agent_ack;
  logic        clken_out;
  logic        clk_active;
  logic [15:0] wake_events;
  logic [1:0]  state_dbg;

  logic [3:0]  sat_ack;
  logic        sat_clken;
  logic        sat_active;
  logic [1:0]  sat_events;
  logic [1:0]  sat_state;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hqm_rcfwl_gclk_clkreq_fsm dut (
    .ckpostdop_free (clk),
    .rst_b          (rst_b),
    .agent_req      (agent_req),
    .agent_ack      (agent_ack),
    .cfg_hyst       (cfg_hyst),
    .cfg_wake_dly   (cfg_wake_dly),
    .fdft_clken     (fdft_clken),
    .clken_out      (clken_out),
    .clk_active     (clk_active),
    .wake_events    (wake_events),
    .state_dbg      (state_dbg)
  );

  hqm_rcfwl_gclk_clkreq_fsm #(.CNT_W(2)) dut_sat (
    .ckpostdop_free (clk),
    .rst_b          (rst_b),
    .agent_req      (agent_req),
    .agent_ack      (sat_ack),
    .cfg_hyst       (cfg_hyst),
    .cfg_wake_dly   (cfg_wake_dly),
    .fdft_clken     (fdft_clken),
    .clken_out      (sat_clken),
    .clk_active     (sat_active),
    .wake_events    (sat_events),
    .state_dbg      (sat_state)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One rising edge, then return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Bounded watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst_b        = 1'b0;
    agent_req    = 4'b0000;
    cfg_hyst     = 8'd5;
    cfg_wake_dly = 4'd3;
    fdft_clken   = 1'b0;
    steps(2);

    // Reset state
    check("rst_state",  32'(state_dbg),   32'(S_OFF));
    check("rst_clken",  32'(clken_out),   32'd0);
    check("rst_ack",    32'(agent_ack),   32'd0);
    check("rst_active", 32'(clk_active),  32'd0);
    check("rst_events", 32'(wake_events), 32'd0);
    fdft_clken = 1'b1;
    #1;
    check("rst_dft_clken", 32'(clken_out), 32'd1);
    fdft_clken = 1'b0;
    #1;
    check("rst_dft_off", 32'(clken_out), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    step();
    check("idle_off", 32'(state_dbg), 32'(S_OFF));

    // Cold wake with D=3: edge N enters WAKE, N+4 reaches ON, N+5 acks.
    agent_req = 4'b0001;
    step();                                   // edge N
    check("cold_clken",  32'(clken_out),   32'd1);
    check("cold_wake",   32'(state_dbg),   32'(S_WAKE));
    check("cold_events", 32'(wake_events), 32'd1);
    steps(3);                                 // edge N+3
    check("cold_still_wake", 32'(state_dbg),  32'(S_WAKE));
    check("cold_not_active", 32'(clk_active), 32'd0);
    step();                                   // edge N+4
    check("cold_active", 32'(clk_active), 32'd1);
    check("cold_ack_lo", 32'(agent_ack),  32'd0);
    step();                                   // edge N+5
    check("cold_ack", 32'(agent_ack), 32'b0001);

    // Warm request in ON: ack follows on the next edge, and drops likewise.
    agent_req = 4'b0011;
    step();
    check("warm_ack", 32'(agent_ack), 32'b0011);
    agent_req = 4'b0001;
    step();
    check("warm_drop", 32'(agent_ack), 32'b0001);

    // Hysteresis expiry with H=5. The mid-count cfg change must be ignored.
    agent_req = 4'b0000;
    step();                                   // edge M
    check("hyst_enter", 32'(state_dbg), 32'(S_HYST));
    check("hyst_ack0",  32'(agent_ack), 32'd0);
    cfg_hyst = 8'd0;
    steps(5);                                 // edge M+5
    check("hyst_hold_state", 32'(state_dbg), 32'(S_HYST));
    check("hyst_hold_clken", 32'(clken_out), 32'd1);
    step();                                   // edge M+6
    check("hyst_gate_clken", 32'(clken_out),   32'd0);
    check("hyst_gate_state", 32'(state_dbg),   32'(S_OFF));
    check("hyst_events",     32'(wake_events), 32'd1);
    cfg_hyst = 8'd5;

    // Hysteresis rescue: a request at M+3 returns to ON without regating.
    agent_req = 4'b0001;
    step();
    check("resc_events_wake", 32'(wake_events), 32'd2);
    steps(4);
    check("resc_on", 32'(state_dbg), 32'(S_ON));
    agent_req = 4'b0000;
    step();                                   // edge M
    check("resc_hyst", 32'(state_dbg), 32'(S_HYST));
    step();
    check("resc_clken1", 32'(clken_out), 32'd1);
    step();                                   // edge M+2
    check("resc_clken2", 32'(clken_out), 32'd1);
    agent_req = 4'b0100;
    step();                                   // edge M+3
    check("resc_state", 32'(state_dbg), 32'(S_ON));
    check("resc_clken", 32'(clken_out), 32'd1);
    check("resc_ack_lo", 32'(agent_ack), 32'd0);
    step();
    check("resc_ack",    32'(agent_ack),   32'b0100);
    check("resc_events", 32'(wake_events), 32'd2);

    // cfg_hyst=0: a single HYST cycle, and a request in that cycle wins.
    cfg_hyst  = 8'd0;
    agent_req = 4'b0000;
    step();
    check("h0_hyst", 32'(state_dbg), 32'(S_HYST));
    agent_req = 4'b1000;
    step();
    check("h0_rescue", 32'(state_dbg), 32'(S_ON));
    agent_req = 4'b0000;
    step();
    check("h0_hyst2", 32'(state_dbg), 32'(S_HYST));
    step();
    check("h0_off",   32'(state_dbg), 32'(S_OFF));
    check("h0_clken", 32'(clken_out), 32'd0);

    // cfg_wake_dly=0: a single WAKE cycle.
    cfg_wake_dly = 4'd0;
    agent_req    = 4'b0010;
    step();
    check("w0_wake", 32'(state_dbg), 32'(S_WAKE));
    step();
    check("w0_on", 32'(state_dbg), 32'(S_ON));
    step();
    check("w0_ack", 32'(agent_ack), 32'b0010);
    agent_req = 4'b0000;
    steps(2);
    check("w0_off", 32'(state_dbg), 32'(S_OFF));

    // Reset mid-WAKE clears everything asynchronously.
    cfg_wake_dly = 4'd3;
    agent_req    = 4'b0001;
    steps(2);
    check("rw_in_wake", 32'(state_dbg), 32'(S_WAKE));
    #2;
    rst_b = 1'b0;
    #1;
    check("rw_clken",  32'(clken_out),   32'd0);
    check("rw_ack",    32'(agent_ack),   32'd0);
    check("rw_state",  32'(state_dbg),   32'(S_OFF));
    check("rw_events", 32'(wake_events), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    step();
    check("rw_rewake",  32'(state_dbg),   32'(S_WAKE));
    check("rw_events1", 32'(wake_events), 32'd1);
    steps(4);
    check("rw_on", 32'(state_dbg), 32'(S_ON));
    agent_req = 4'b0000;
    steps(2);
    check("rw_off", 32'(state_dbg), 32'(S_OFF));

    // DFT override in OFF with no requests.
    fdft_clken = 1'b1;
    #1;
    check("dft_clken", 32'(clken_out), 32'd1);
    step();
    check("dft_state", 32'(state_dbg), 32'(S_OFF));
    check("dft_ack",   32'(agent_ack), 32'd0);
    check("dft_hold",  32'(clken_out), 32'd1);
    fdft_clken = 1'b0;
    #1;
    check("dft_release", 32'(clken_out), 32'd0);

    // Saturation with CNT_W=2: five full wake/gate cycles from reset.
    @(negedge clk);
    rst_b = 1'b0;
    step();
    rst_b        = 1'b1;
    cfg_wake_dly = 4'd0;
    cfg_hyst     = 8'd0;
    step();
    for (int k = 0; k < 5; k++) begin
      agent_req = 4'b0001;
      step();                                 // enter WAKE
      check($sformatf("sat_cnt%0d", k), 32'(sat_events), 32'(sat_exp[k]));
      check($sformatf("sat_main%0d", k), 32'(wake_events), 32'(k + 1));
      step();                                 // ON
      agent_req = 4'b0000;
      step();                                 // HYST
      step();                                 // OFF
      check($sformatf("sat_off%0d", k), 32'(sat_state), 32'(S_OFF));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
